// File: rtl/asrv32_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, one-entry skid, redirect flush.
// Optional ASRV32_FETCH_MISALIGN_EN: a misaligned redirect target halts fetch and raises o_misaligned.
module asrv32_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misaligned
);

`ifdef ASRV32_FETCH_MISALIGN_EN
    typedef enum logic [1:0] {S_FETCH, S_STALL, S_DRAIN, S_HALT} state_t;
    wire [31:0] tgt       = i_redirect_pc;
    wire        redir_mis = |i_redirect_pc[1:0];
`else
    typedef enum logic [1:0] {S_FETCH, S_STALL, S_DRAIN} state_t;
    wire [31:0] tgt = i_redirect_pc & 32'hFFFF_FFFC;
    assign o_misaligned = 1'b0;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        skid_v;

    wire ack     = i_imem_ack & o_imem_req;
    wire consume = o_valid & ~i_stall;
    // Acks that land in DRAIN belong to a flushed request and are never accepted.
    wire accept  = ack & (state == S_FETCH);
    wire direct  = (~o_valid | consume) & ~skid_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_FETCH;
            pc          <= PC_RESET;
            o_imem_req  <= 1'b0;
            o_imem_addr <= PC_RESET;
            o_inst      <= 32'h0;
            o_pc        <= 32'h0;
            o_valid     <= 1'b0;
            skid_inst   <= 32'h0;
            skid_pc     <= 32'h0;
            skid_v      <= 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
            o_misaligned <= 1'b0;
`endif
        end else if (i_redirect) begin
            o_valid <= 1'b0;
            skid_v  <= 1'b0;
            pc      <= tgt;
`ifdef ASRV32_FETCH_MISALIGN_EN
            o_misaligned <= redir_mis;
            if (redir_mis) o_pc <= tgt;
`endif
            // An unacked request must finish on the bus before the new target is issued.
            if (o_imem_req && !i_imem_ack) begin
                state <= S_DRAIN;
            end
`ifdef ASRV32_FETCH_MISALIGN_EN
            else if (redir_mis) begin
                state      <= S_HALT;
                o_imem_req <= 1'b0;
            end
`endif
            else begin
                state       <= S_FETCH;
                o_imem_req  <= 1'b1;
                o_imem_addr <= tgt;
            end
        end else begin
            if (consume && skid_v) begin
                o_inst <= skid_inst;
                o_pc   <= skid_pc;
                skid_v <= 1'b0;
            end else if (consume) begin
                o_valid <= 1'b0;
            end
            if (accept) begin
                if (direct) begin
                    o_inst  <= i_imem_rdata;
                    o_pc    <= o_imem_addr;
                    o_valid <= 1'b1;
                end else begin
                    skid_inst <= i_imem_rdata;
                    skid_pc   <= o_imem_addr;
                    skid_v    <= 1'b1;
                end
                pc <= o_imem_addr + 32'd4;
            end

            unique case (state)
                S_FETCH: begin
                    if (!o_imem_req) begin
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= pc;
                    end else if (ack) begin
                        if (!direct && !consume) begin
                            state      <= S_STALL;
                            o_imem_req <= 1'b0;
                        end else begin
                            o_imem_addr <= o_imem_addr + 32'd4;
                        end
                    end
                end
                S_STALL: begin
                    if (consume) begin
                        state       <= S_FETCH;
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= pc;
                    end
                end
                S_DRAIN: begin
                    if (ack) begin
                        o_imem_addr <= pc;
`ifdef ASRV32_FETCH_MISALIGN_EN
                        if (o_misaligned) begin
                            state      <= S_HALT;
                            o_imem_req <= 1'b0;
                        end else begin
                            state <= S_FETCH;
                        end
`else
                        state <= S_FETCH;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
